// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, an iterative shift-add multiplier
// and a sticky carry flag for chaining multi-word additions.
module alu_seq #(
  parameter int BUS_WIDTH      = 8,
  parameter bit USE_FLAG_CARRY = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic [BUS_WIDTH-1:0] y_hi,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(BUS_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_DEC  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_XOR  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    y_q, y_d, y_hi_q, y_hi_d;
  logic            carry_q, carry_d, borrow_q, borrow_d;
  logic            zero_q, zero_d, parity_q, parity_d, invalid_q, invalid_d;
  logic            carry_flag_q, carry_flag_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            carry_sel;
  logic [W:0]      alu_sum;
  logic [W-1:0]    alu_y;
  logic            alu_carry, alu_borrow, alu_invalid;
  logic [W:0]      mul_add;
  logic [2*W-1:0]  acc_step;
  logic            accept;
  logic            wr_en, wr_carry, wr_borrow, wr_invalid;
  logic [W-1:0]    wr_y, wr_hi;

  // Single-cycle datapath; MUL is not flagged invalid but is produced by the multiplier.
  always_comb begin
    carry_sel   = USE_FLAG_CARRY ? carry_flag_q : carry_in;
    alu_sum     = '0;
    alu_y       = '0;
    alu_carry   = 1'b0;
    alu_borrow  = 1'b0;
    alu_invalid = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_sum   = {1'b0, a} + {1'b0, b};
        alu_y     = alu_sum[W-1:0];
        alu_carry = alu_sum[W];
      end
      OP_ADDC: begin
        alu_sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_sel};
        alu_y     = alu_sum[W-1:0];
        alu_carry = alu_sum[W];
      end
      OP_SUB: begin
        alu_y      = a - b;
        alu_borrow = (a < b);
      end
      OP_INC: begin
        alu_sum   = {1'b0, a} + {{W{1'b0}}, 1'b1};
        alu_y     = alu_sum[W-1:0];
        alu_carry = alu_sum[W];
      end
      OP_DEC: begin
        alu_y      = a - {{(W-1){1'b0}}, 1'b1};
        alu_borrow = (a == '0);
      end
      OP_AND:  alu_y = a & b;
      OP_NOT:  alu_y = ~a;
      OP_ROL:  alu_y = {a[W-2:0], a[W-1]};
      OP_ROR:  alu_y = {a[0], a[W-1:1]};
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_MUL:  alu_y = '0;
      default: alu_invalid = 1'b1;
    endcase
  end

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // The multiplier keeps {partial product, remaining multiplier bits} in one
  // register and retires one multiplier bit per step.
  assign mul_add  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
  assign acc_step = {mul_add, acc_q[W-1:1]};

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    y_hi_d       = y_hi_q;
    carry_d      = carry_q;
    borrow_d     = borrow_q;
    zero_d       = zero_q;
    parity_d     = parity_q;
    invalid_d    = invalid_q;
    carry_flag_d = carry_flag_q;
    mcand_d      = mcand_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    wr_en        = 1'b0;
    wr_y         = '0;
    wr_hi        = '0;
    wr_carry     = 1'b0;
    wr_borrow    = 1'b0;
    wr_invalid   = 1'b0;

    case (state_q)
      MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_STEP) begin
          wr_en    = 1'b1;
          wr_y     = acc_step[W-1:0];
          wr_hi    = acc_step[2*W-1:W];
          wr_carry = |acc_step[2*W-1:W];
          state_d  = HOLD;
        end
      end
      default: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            mcand_d = a;
            acc_d   = {{W{1'b0}}, b};
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            wr_en      = 1'b1;
            wr_y       = alu_y;
            wr_carry   = alu_carry;
            wr_borrow  = alu_borrow;
            wr_invalid = alu_invalid;
            state_d    = HOLD;
          end
        end else if ((state_q == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
    endcase

    // Non-carry ops report carry_out=0, so loading it also clears the flag for them.
    if (wr_en) begin
      y_d       = wr_y;
      y_hi_d    = wr_hi;
      carry_d   = wr_carry;
      borrow_d  = wr_borrow;
      zero_d    = (wr_y == '0) && (wr_hi == '0);
      parity_d  = ^wr_y;
      invalid_d = wr_invalid;
      if (!wr_invalid) carry_flag_d = wr_carry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      y_q          <= '0;
      y_hi_q       <= '0;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      zero_q       <= 1'b0;
      parity_q     <= 1'b0;
      invalid_q    <= 1'b0;
      carry_flag_q <= 1'b0;
      mcand_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      y_hi_q       <= y_hi_d;
      carry_q      <= carry_d;
      borrow_q     <= borrow_d;
      zero_q       <= zero_d;
      parity_q     <= parity_d;
      invalid_q    <= invalid_d;
      carry_flag_q <= carry_flag_d;
      mcand_q      <= mcand_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign y          = y_q;
  assign y_hi       = y_hi_q;
  assign carry_out  = carry_q;
  assign borrow     = borrow_q;
  assign zero       = zero_q;
  assign parity     = parity_q;
  assign invalid_op = invalid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (BUS_WIDTH=8, USE_FLAG_CARRY=1): expected results
// are queued on accept and compared against results observed on output transfers.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] hi;
    logic       c;
    logic       bo;
    logic       z;
    logic       p;
    logic       inv;
  } res_t;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [7:0] y_hi;
  logic       carry_out;
  logic       borrow;
  logic       zero;
  logic       parity;
  logic       invalid_op;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic mflag    = 1'b0;
  res_t exp_q[$];
  res_t obs_q[$];

  alu_seq #(.BUS_WIDTH(8), .USE_FLAG_CARRY(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_hi(y_hi),
    .carry_out(carry_out), .borrow(borrow), .zero(zero), .parity(parity),
    .invalid_op(invalid_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t observe();
    res_t r;
    r.y = y; r.hi = y_hi; r.c = carry_out; r.bo = borrow;
    r.z = zero; r.p = parity; r.inv = invalid_op;
    return r;
  endfunction

  // Reference behaviour, including the sticky carry flag, evaluated in issue order.
  function automatic res_t model(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb);
    res_t r;
    logic [15:0] w;
    r = '0;
    w = '0;
    case (op)
      4'd1:  begin w = 16'(aa) + 16'(bb); r.y = w[7:0]; r.c = w[8]; end
      4'd2:  begin w = 16'(aa) + 16'(bb) + 16'(mflag); r.y = w[7:0]; r.c = w[8]; end
      4'd3:  begin r.y = aa - bb; r.bo = (aa < bb); end
      4'd4:  begin w = 16'(aa) + 16'd1; r.y = w[7:0]; r.c = w[8]; end
      4'd5:  begin r.y = aa - 8'd1; r.bo = (aa == 8'd0); end
      4'd6:  r.y = aa & bb;
      4'd7:  r.y = ~aa;
      4'd8:  r.y = {aa[6:0], aa[7]};
      4'd9:  r.y = {aa[0], aa[7:1]};
      4'd10: r.y = aa | bb;
      4'd11: r.y = aa ^ bb;
      4'd12: begin w = 16'(aa) * 16'(bb); r.y = w[7:0]; r.hi = w[15:8]; r.c = |w[15:8]; end
      default: r.inv = 1'b1;
    endcase
    r.z = (r.y == 8'd0) && (r.hi == 8'd0);
    r.p = ^r.y;
    if (!r.inv) mflag = (op == 4'd1 || op == 4'd2 || op == 4'd4 || op == 4'd12) ? r.c : 1'b0;
    return r;
  endfunction

  // Output transfers are captured between the falling and the next rising edge.
  always @(negedge clk) begin
    #2;
    if (reset_n && out_valid && out_ready) obs_q.push_back(observe());
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                       output int acc_cyc);
    bit done;
    done = 1'b0;
    opcode = op; a = aa; b = bb; carry_in = ~mflag; in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(model(op, aa, bb));
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    acc_cyc = cyc;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL issue_accept op=%0d accepted=%0b required=1", op, done);
    end
  endtask

  task automatic wait_obs(input int n);
    int i;
    i = 0;
    while (obs_q.size() < n && i < 60) begin
      @(negedge clk); #3; i++;
    end
    checks++;
    if (obs_q.size() < n) begin
      failures++;
      $display("[TB] FAIL result_timeout got=%0d results required=%0d", obs_q.size(), n);
    end
  endtask

  task automatic settle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    res_t o;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; a = '0; b = '0; carry_in = 1'b0; mflag = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    o = observe();
    checks++;
    if (out_valid !== 1'b0 || o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got out_valid=%b res=%h required 0/0", out_valid, o);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    int t0;
    res_t e, o;
    out_ready = 1'b1;
    issue(4'd1, 8'd9, 8'd33, t0);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL add_latency out_valid got=%b required=1", out_valid);
    end
    wait_obs(1);
    e = '1; o = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    if (obs_q.size() != 0) o = obs_q.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("[TB] FAIL add_result got=%h required=%h", o, e);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    res_t e, o;
    out_ready = 1'b1;
    issue(4'd1, 8'd200, 8'd100, t1);
    issue(4'd2, 8'd0, 8'd0, t2);
    in_valid = 1'b0;
    checks++;
    if (t2 !== t1 + 1) begin
      failures++;
      $display("[TB] FAIL b2b_issue_gap got=%0d cycles required=1", t2 - t1);
    end
    wait_obs(2);
    for (int k = 0; k < 2; k++) begin
      e = '1; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL b2b_result[%0d] got=%h required=%h", k, o, e);
      end
    end
    settle();
  endtask

  task automatic test_arith_edges();
    int t;
    res_t e, o;
    out_ready = 1'b1;
    issue(4'd3, 8'd65, 8'd66, t);
    issue(4'd5, 8'd0, 8'd0, t);
    issue(4'd4, 8'd255, 8'd0, t);
    issue(4'd11, 8'hA5, 8'h0F, t);
    in_valid = 1'b0;
    wait_obs(4);
    for (int k = 0; k < 4; k++) begin
      e = '1; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL edge_result[%0d] got=%h required=%h", k, o, e);
      end
    end
    settle();
  endtask

  task automatic test_mul();
    int t0, busy_bad;
    res_t e, o;
    out_ready = 1'b1;
    issue(4'd12, 8'd200, 8'd3, t0);
    opcode = 4'd1; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    busy_bad = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("[TB] FAIL mul_busy got=%0d bad cycles required=0", busy_bad);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mul_latency out_valid at accept+9 got=%b required=1", out_valid);
    end
    wait_obs(1);
    e = '1; o = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    if (obs_q.size() != 0) o = obs_q.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("[TB] FAIL mul_result got=%h required=%h", o, e);
    end
    settle();
  endtask

  task automatic test_backpressure();
    int t0, bad;
    res_t e, o;
    out_ready = 1'b0;
    issue(4'd8, 8'h81, 8'h00, t0);
    in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 8'h03) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL bp_hold got=%0d unstable cycles required=0", bad);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("[TB] FAIL bp_transfers got=%0d required=1", obs_q.size());
    end
    e = '1; o = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    if (obs_q.size() != 0) o = obs_q.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("[TB] FAIL bp_result got=%h required=%h", o, e);
    end
    while (obs_q.size() != 0) void'(obs_q.pop_front());
    settle();
  endtask

  task automatic test_invalid();
    int t;
    res_t e, o;
    out_ready = 1'b1;
    issue(4'd1, 8'd200, 8'd100, t);
    issue(4'd14, 8'd7, 8'd7, t);
    issue(4'd0, 8'd3, 8'd3, t);
    issue(4'd2, 8'd0, 8'd0, t);
    in_valid = 1'b0;
    wait_obs(4);
    for (int k = 0; k < 4; k++) begin
      e = '1; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL invalid_seq[%0d] got=%h required=%h", k, o, e);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid_mul();
    int t;
    res_t e, o;
    out_ready = 1'b1;
    issue(4'd12, 8'd7, 8'd9, t);
    in_valid = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    o = observe();
    checks++;
    if (out_valid !== 1'b0 || o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_mul got out_valid=%b res=%h required 0/0", out_valid, o);
    end
    mflag = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(4'd1, 8'd5, 8'd6, t);
    issue(4'd2, 8'd1, 8'd1, t);
    in_valid = 1'b0;
    wait_obs(2);
    for (int k = 0; k < 2; k++) begin
      e = '1; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL post_reset[%0d] got=%h required=%h", k, o, e);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_arith_edges();
    test_mul();
    test_backpressure();
    test_invalid();
    test_reset_mid_mul();
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL leftover_results got exp=%0d obs=%0d required 0/0", exp_q.size(), obs_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout required=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
